// File: rtl/dbg_step_ctrl.sv
// ----------------------------------------------------------------------------
// dbg_step_ctrl
//
// Step/run controller for the debug unit. It accepts command bytes from the
// host UART and advances the pipeline one step, N steps, or freely until the
// program halts. After each step command or run it triggers one debug-data
// dump. It reports completion when the program halts or the host sends EXIT.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-low reset
//   i_start         enter step mode (only honoured in IDLE)
//   i_rx_data       received command/operand byte
//   i_rx_done       1-cycle strobe, i_rx_data valid
//   i_done_send     debug-data send engine finished
//   i_pipe_running  1 while the program has not halted
//   o_step          pipeline advance enable, one cycle per step
//   o_start_send    1-cycle pulse, start a debug dump
//   o_done          1-cycle pulse, step mode finished
//   o_busy          high in every state except IDLE
//   o_steps_done    o_step cycles since the last accepted i_start (saturating)
// ----------------------------------------------------------------------------
module dbg_step_ctrl #(
   parameter int                DATA_W    = 8,
   parameter int                CNT_W     = 8,
   parameter logic [DATA_W-1:0] CMD_STEP  = 8'h0F,
   parameter logic [DATA_W-1:0] CMD_STEPN = 8'h0E,
   parameter logic [DATA_W-1:0] CMD_RUN   = 8'h10,
   parameter logic [DATA_W-1:0] CMD_EXIT  = 8'h1F,
   parameter int                SETTLE    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_rx_done,
   input  logic              i_done_send,
   input  logic              i_pipe_running,
   output logic              o_step,
   output logic              o_start_send,
   output logic              o_done,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_steps_done
);

   // The settle counter only has to hold SETTLE-1.
   localparam int                   SETTLE_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_MAX     = '1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_CMD,
      S_WAIT_CNT,
      S_STEP,
      S_SETTLE,
      S_SEND,
      S_WAIT_SEND,
      S_CHECK,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     remaining;
   logic [CNT_W-1:0]     remaining_nxt;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic [SETTLE_W-1:0]  settle_nxt;
   logic [CNT_W-1:0]     steps_cnt;
   logic                 clear_steps;
   logic                 step_q;
   logic                 send_q;
   logic                 done_q;
   logic                 busy_q;
   logic                 run_step;

   // In RUN the pipeline advances in exactly the cycles where it is still
   // running, so that one enable has to follow i_pipe_running within the
   // same cycle. Every other output comes straight from a flop.
   assign run_step     = (state == S_RUN) && i_pipe_running;
   assign o_step       = step_q | run_step;
   assign o_start_send = send_q;
   assign o_done       = done_q;
   assign o_busy       = busy_q;
   assign o_steps_done = steps_cnt;

   // Next-state and datapath decisions. Received bytes are only looked at
   // while waiting for a command or an operand; anywhere else they are
   // simply dropped. A halt seen at the end of a settle window cuts a burst
   // short, but the dump still goes out once.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      settle_nxt    = settle_cnt;
      clear_steps   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nxt   = S_WAIT_CMD;
               clear_steps = 1'b1;
            end
         end
         S_WAIT_CMD: begin
            if (i_rx_done) begin
               if (i_rx_data == CMD_STEP) begin
                  remaining_nxt = CNT_ONE;
                  state_nxt     = S_STEP;
               end else if (i_rx_data == CMD_STEPN) begin
                  state_nxt = S_WAIT_CNT;
               end else if (i_rx_data == CMD_RUN) begin
                  state_nxt = S_RUN;
               end else if (i_rx_data == CMD_EXIT) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_WAIT_CNT: begin
            if (i_rx_done) begin
               remaining_nxt = i_rx_data[CNT_W-1:0];
               state_nxt     = (i_rx_data[CNT_W-1:0] == '0) ? S_WAIT_CMD : S_STEP;
            end
         end
         S_STEP: begin
            remaining_nxt = remaining - CNT_ONE;
            settle_nxt    = SETTLE_LOAD;
            state_nxt     = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt != '0) begin
               settle_nxt = settle_cnt - SETTLE_W'(1);
            end else if ((remaining != '0) && i_pipe_running) begin
               state_nxt = S_STEP;
            end else begin
               state_nxt = S_SEND;
            end
         end
         S_RUN: begin
            if (!i_pipe_running) begin
               remaining_nxt = '0;
               settle_nxt    = SETTLE_LOAD;
               state_nxt     = S_SETTLE;
            end
         end
         S_SEND: begin
            state_nxt = S_WAIT_SEND;
         end
         S_WAIT_SEND: begin
            if (i_done_send) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            state_nxt = i_pipe_running ? S_WAIT_CMD : S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            // Unreachable encodings fall back to a clean IDLE.
            state_nxt     = S_IDLE;
            remaining_nxt = '0;
            settle_nxt    = '0;
         end
      endcase
   end

   // State register. The state-only outputs are registered from the next
   // state so they line up exactly with the state they belong to. The step
   // counter counts every cycle o_step is high and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         remaining  <= '0;
         settle_cnt <= '0;
         steps_cnt  <= '0;
         step_q     <= 1'b0;
         send_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         remaining  <= remaining_nxt;
         settle_cnt <= settle_nxt;
         step_q     <= (state_nxt == S_STEP);
         send_q     <= (state_nxt == S_SEND);
         done_q     <= (state_nxt == S_DONE);
         busy_q     <= (state_nxt != S_IDLE);
         if (clear_steps) begin
            steps_cnt <= '0;
         end else if (o_step && (steps_cnt != CNT_MAX)) begin
            steps_cnt <= steps_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dbg_step_ctrl
//
// Self-checking bench for dbg_step_ctrl. Each scenario task pushes the output
// events it expects (kind and cycle) into a scoreboard queue while driving
// stimulus; tick() records the events the DUT actually produces, and the task
// then pops both queues and compares them, alongside inline level checks.
// ----------------------------------------------------------------------------
module tb_dbg_step_ctrl;

   localparam int EV_STEP = 0;
   localparam int EV_SEND = 1;
   localparam int EV_DONE = 2;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       i_done_send;
   logic       i_pipe_running;
   logic       o_step;
   logic       o_start_send;
   logic       o_done;
   logic       o_busy;
   logic [7:0] o_steps_done;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_fail = 0;

   ev_t exp_q[$];
   ev_t obs_q[$];

   logic       s_step;
   logic       s_send;
   logic       s_done;
   logic       s_busy;
   logic [7:0] s_steps;

   dbg_step_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_rx_data      (i_rx_data),
      .i_rx_done      (i_rx_done),
      .i_done_send    (i_done_send),
      .i_pipe_running (i_pipe_running),
      .o_step         (o_step),
      .o_start_send   (o_start_send),
      .o_done         (o_done),
      .o_busy         (o_busy),
      .o_steps_done   (o_steps_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sample at the falling edge of the current cycle, log events, then
   // return just after the next rising edge so the caller can drive inputs.
   task automatic tick();
      ev_t ev;
      @(negedge clk);
      s_step  = o_step;
      s_send  = o_start_send;
      s_done  = o_done;
      s_busy  = o_busy;
      s_steps = o_steps_done;
      ev.cyc  = cyc;
      if (o_step === 1'b1)       begin ev.kind = EV_STEP; obs_q.push_back(ev); end
      if (o_start_send === 1'b1) begin ev.kind = EV_SEND; obs_q.push_back(ev); end
      if (o_done === 1'b1)       begin ev.kind = EV_DONE; obs_q.push_back(ev); end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
   endtask

   task automatic finish_send();
      i_done_send = 1'b1;
      tick();
      i_done_send = 1'b0;
   endtask

   task automatic push_ev(input int kind, input int c);
      ev_t ev;
      ev.kind = kind;
      ev.cyc  = c;
      exp_q.push_back(ev);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i_start = 1'b1;
      ticks(3);
      n_cmp++;
      if ({s_step, s_send, s_done, s_busy} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 0000", {s_step, s_send, s_done, s_busy});
      end
      n_cmp++;
      if (s_steps !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_steps: got %h expected 00", s_steps);
      end
      i_start = 1'b0;
      rst = 1'b1;
      ticks(2);
      n_cmp++;
      if (s_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_idle_busy: got %b expected 0", s_busy);
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL reset_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_single_step();
      int  t;
      ev_t e, o;
      i_pipe_running = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      t = cyc;
      push_ev(EV_STEP, t + 1);
      push_ev(EV_SEND, t + 4);
      send_byte(8'h0F);
      ticks(6);
      finish_send();
      ticks(2);
      n_cmp++;
      if (s_busy !== 1'b1 || s_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_back_to_cmd: got busy=%b done=%b expected busy=1 done=0", s_busy, s_done);
      end
      n_cmp++;
      if (s_steps !== 8'd1) begin
         n_fail++;
         $display("[TB] FAIL single_steps: got %0d expected 1", s_steps);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL single_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL single_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL single_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_step_n();
      int  t;
      ev_t e, o;
      t = cyc;
      push_ev(EV_STEP, t + 2);
      push_ev(EV_STEP, t + 5);
      push_ev(EV_STEP, t + 8);
      push_ev(EV_SEND, t + 11);
      send_byte(8'h0E);
      send_byte(8'h03);
      ticks(11);
      finish_send();
      ticks(2);
      n_cmp++;
      if (s_steps !== 8'd4) begin
         n_fail++;
         $display("[TB] FAIL stepn_steps: got %0d expected 4", s_steps);
      end
      // N = 0 must be a no-op that leaves the controller taking commands.
      send_byte(8'h0E);
      send_byte(8'h00);
      ticks(5);
      n_cmp++;
      if (s_busy !== 1'b1 || s_steps !== 8'd4) begin
         n_fail++;
         $display("[TB] FAIL stepn_zero: got busy=%b steps=%0d expected busy=1 steps=4", s_busy, s_steps);
      end
      t = cyc;
      push_ev(EV_STEP, t + 1);
      push_ev(EV_SEND, t + 4);
      send_byte(8'h0F);
      ticks(6);
      finish_send();
      ticks(2);
      n_cmp++;
      if (s_steps !== 8'd5) begin
         n_fail++;
         $display("[TB] FAIL stepn_after_zero_steps: got %0d expected 5", s_steps);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL stepn_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL stepn_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL stepn_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_early_halt();
      int  t;
      ev_t e, o;
      t = cyc;
      push_ev(EV_STEP, t + 2);
      push_ev(EV_STEP, t + 5);
      push_ev(EV_SEND, t + 8);
      push_ev(EV_DONE, t + 12);
      send_byte(8'h0E);
      send_byte(8'h05);
      ticks(4);
      i_pipe_running = 1'b0;
      ticks(4);
      finish_send();
      ticks(3);
      n_cmp++;
      if (s_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL halt_idle_busy: got %b expected 0", s_busy);
      end
      n_cmp++;
      if (s_steps !== 8'd7) begin
         n_fail++;
         $display("[TB] FAIL halt_steps: got %0d expected 7", s_steps);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL halt_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL halt_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL halt_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_run(input int n_run, input logic [7:0] exp_steps);
      int  t;
      ev_t e, o;
      i_pipe_running = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      t = cyc;
      for (int i = 1; i <= n_run; i++) push_ev(EV_STEP, t + i);
      push_ev(EV_SEND, t + n_run + 4);
      push_ev(EV_DONE, t + n_run + 7);
      send_byte(8'h10);
      n_cmp++;
      if (s_steps !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL run_start_clear: got %0d expected 0", s_steps);
      end
      ticks(n_run);
      i_pipe_running = 1'b0;
      ticks(4);
      finish_send();
      ticks(3);
      n_cmp++;
      if (s_steps !== exp_steps) begin
         n_fail++;
         $display("[TB] FAIL run_steps: got %0d expected %0d", s_steps, exp_steps);
      end
      n_cmp++;
      if (s_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL run_idle_busy: got %b expected 0", s_busy);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL run_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL run_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL run_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
      i_pipe_running = 1'b1;
   endtask

   task automatic test_exit_ignore();
      int  t;
      ev_t e, o;
      i_pipe_running = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      send_byte(8'hAA);
      ticks(3);
      n_cmp++;
      if (s_busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL exit_unknown_cmd: got busy=%b expected 1", s_busy);
      end
      t = cyc;
      push_ev(EV_STEP, t + 1);
      push_ev(EV_SEND, t + 4);
      send_byte(8'h0F);
      ticks(5);
      send_byte(8'h10);
      ticks(1);
      finish_send();
      ticks(1);
      t = cyc;
      push_ev(EV_DONE, t + 1);
      send_byte(8'h1F);
      ticks(2);
      n_cmp++;
      if (s_busy !== 1'b0 || s_steps !== 8'd1) begin
         n_fail++;
         $display("[TB] FAIL exit_idle: got busy=%b steps=%0d expected busy=0 steps=1", s_busy, s_steps);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL exit_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL exit_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL exit_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid_burst();
      int  t;
      ev_t e, o;
      i_pipe_running = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      t = cyc;
      push_ev(EV_STEP, t + 2);
      send_byte(8'h0E);
      send_byte(8'h04);
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({s_step, s_send, s_done, s_busy} !== 4'b0000 || s_steps !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_outputs: got flags=%b steps=%0d expected flags=0000 steps=0", {s_step, s_send, s_done, s_busy}, s_steps);
      end
      rst = 1'b1;
      ticks(3);
      send_byte(8'h0F);
      ticks(4);
      n_cmp++;
      if (s_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_needs_start: got busy=%b expected 0", s_busy);
      end
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      t = cyc;
      push_ev(EV_STEP, t + 1);
      push_ev(EV_SEND, t + 4);
      send_byte(8'h0F);
      ticks(6);
      finish_send();
      ticks(2);
      n_cmp++;
      if (s_steps !== 8'd1) begin
         n_fail++;
         $display("[TB] FAIL midreset_resume_steps: got %0d expected 1", s_steps);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
               n_fail++;
               $display("[TB] FAIL midreset_event: got kind %0d at %0d expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL midreset_extra_events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      rst            = 1'b0;
      i_start        = 1'b0;
      i_rx_data      = 8'h00;
      i_rx_done      = 1'b0;
      i_done_send    = 1'b0;
      i_pipe_running = 1'b1;
      $display("[TB] dbg_step_ctrl bench starting");
      test_reset();
      test_single_step();
      test_step_n();
      test_early_halt();
      test_run(10, 8'd10);
      test_exit_ignore();
      test_run(300, 8'hFF);
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
